uart_word_assembler: RTL

- Parametrised successor to the two-byte receive-and-display path.
- Assembles NUM_BYTES consecutive received UART bytes into one word.
- Adds configurable byte order, inter-byte timeout, error latching and an explicit word handshake.
- Sits between the UART receiver and the display or consumer logic, in the receiver's clock domain.

---
 rtl/uart_word_assembler_pkg.sv | 21 ++
 rtl/uart_word_assembler_if.sv | 54 +++++
 rtl/uart_word_assembler_inter_byte_timer.sv | 42 ++++
 rtl/uart_word_assembler.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/uart_word_assembler_pkg.sv
// Shared types, constants and slot-placement helper for the UART word assembler.
package uart_word_assembler_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int BYTE_W      = 8;
    localparam int ERR_CNT_MAX = 255;

    // Bit position of the least significant bit of the k-th received byte
    // inside the assembled word, for either byte order.
    function automatic int slot_lsb(input int k, input int numBytes, input bit msbFirst);
        if (msbFirst) begin
            return BYTE_W * (numBytes - 1 - k);
        end
        return BYTE_W * k;
    endfunction

endpackage

// File: rtl/uart_word_assembler_if.sv
// Receive-side byte stream and word-side results of the UART word assembler.
// The master drives received bytes and flush; the slave produces the word.
interface uart_word_assembler_if #(
    parameter int NUM_BYTES = 2
);

    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ferror;
    logic                   rx_perror;
    logic                   flush;

    logic [8*NUM_BYTES-1:0] word_data;
    logic                   word_valid;
    logic [8*NUM_BYTES-1:0] display_word;
    logic                   error_flag;
    logic                   timeout_pulse;
    logic [2:0]             byte_count;
    logic                   busy;
    logic [7:0]             err_count;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_ferror,
        output rx_perror,
        output flush,
        input  word_data,
        input  word_valid,
        input  display_word,
        input  error_flag,
        input  timeout_pulse,
        input  byte_count,
        input  busy,
        input  err_count
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_ferror,
        input  rx_perror,
        input  flush,
        output word_data,
        output word_valid,
        output display_word,
        output error_flag,
        output timeout_pulse,
        output byte_count,
        output busy,
        output err_count
    );

endinterface

// File: rtl/uart_word_assembler_inter_byte_timer.sv
// Loadable down-counter that bounds the gap between bytes of one word.
// A load sets it to TIMEOUT_CYCLES-1; while enabled it counts down and
// then rests at zero, where expired_o stays high until the next load.
module uart_word_assembler_inter_byte_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int             CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Reload has priority over counting; the counter never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VALUE;
        end else if (enable_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    // Counter register, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/uart_word_assembler.sv
// Collects NUM_BYTES good UART bytes into one word with selectable byte
// order. Errored bytes, flush and inter-byte timeout all discard the
// partial word; errors are latched and counted, and the display output
// shows all ones while the error latch is set.
module uart_word_assembler #(
    parameter int NUM_BYTES      = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MSB_FIRST      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_word_assembler_if.slave  bus
);

    import uart_word_assembler_pkg::*;

    localparam int         WORD_W    = BYTE_W * NUM_BYTES;
    localparam logic [7:0] ERR_SAT   = 8'(ERR_CNT_MAX);
    localparam logic [2:0] LAST_SLOT = 3'(NUM_BYTES - 1);

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          byteCount_q;
    logic [2:0]          byteCount_d;
    logic [WORD_W-1:0]   wordData_q;
    logic [WORD_W-1:0]   wordData_d;
    logic                wordValid_q;
    logic                wordValid_d;
    logic                errFlag_q;
    logic                errFlag_d;
    logic                timeoutPulse_q;
    logic                timeoutPulse_d;
    logic [7:0]          errCount_q;
    logic [7:0]          errCount_d;

    logic [WORD_W-1:0]   assembled;
    logic                goodByte;
    logic                badByte;
    logic                lastByte;
    logic                acceptByte;
    logic                timerLoad;
    logic                timerEnable;
    logic                timerExpired;

    assign goodByte = bus.rx_valid && !bus.rx_ferror && !bus.rx_perror;
    assign badByte  = bus.rx_valid && (bus.rx_ferror || bus.rx_perror);
    assign lastByte = (byteCount_q == LAST_SLOT);

    // One byte register per slot, placed in the word according to the byte
    // order. The incoming byte is forwarded straight into the assembled word
    // so that the completing byte lands in word_data on the same edge.
    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_slot
        localparam int LSB = slot_lsb(k, NUM_BYTES, MSB_FIRST != 0);

        logic              slotWrite;
        logic [BYTE_W-1:0] slot_q;
        logic [BYTE_W-1:0] slot_d;

        assign slotWrite = acceptByte && (byteCount_q == 3'(k));
        assign slot_d    = slotWrite ? bus.rx_data : slot_q;
        assign assembled[LSB +: BYTE_W] = slot_d;

        // Slot byte register; stale contents are always overwritten before
        // the slot is read out as part of a completed word.
        always_ff @(posedge clk) begin
            if (!reset) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end
    end

    // Next-state logic in priority order: flush, errored byte, good byte,
    // then timer expiry (which only matters while collecting).
    always_comb begin
        state_d        = state_q;
        byteCount_d    = byteCount_q;
        wordData_d     = wordData_q;
        wordValid_d    = 1'b0;
        errFlag_d      = errFlag_q;
        timeoutPulse_d = 1'b0;
        errCount_d     = errCount_q;
        acceptByte     = 1'b0;
        timerLoad      = 1'b0;

        if (bus.flush) begin
            state_d     = IDLE;
            byteCount_d = '0;
        end else if (badByte) begin
            state_d     = IDLE;
            byteCount_d = '0;
            errFlag_d   = 1'b1;
            if (errCount_q != ERR_SAT) begin
                errCount_d = errCount_q + 8'd1;
            end
        end else if (goodByte) begin
            acceptByte = 1'b1;
            if (lastByte) begin
                state_d     = IDLE;
                byteCount_d = '0;
                wordData_d  = assembled;
                wordValid_d = 1'b1;
                errFlag_d   = 1'b0;
            end else begin
                state_d     = COLLECT;
                byteCount_d = byteCount_q + 3'd1;
                timerLoad   = 1'b1;
            end
        end else if ((state_q == COLLECT) && timerExpired) begin
            state_d        = IDLE;
            byteCount_d    = '0;
            timeoutPulse_d = 1'b1;
        end
    end

    // Control and output registers, all cleared by reset with no pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            byteCount_q    <= '0;
            wordData_q     <= '0;
            wordValid_q    <= 1'b0;
            errFlag_q      <= 1'b0;
            timeoutPulse_q <= 1'b0;
            errCount_q     <= '0;
        end else begin
            state_q        <= state_d;
            byteCount_q    <= byteCount_d;
            wordData_q     <= wordData_d;
            wordValid_q    <= wordValid_d;
            errFlag_q      <= errFlag_d;
            timeoutPulse_q <= timeoutPulse_d;
            errCount_q     <= errCount_d;
        end
    end

    assign timerEnable = (state_q == COLLECT);

    uart_word_assembler_inter_byte_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (timerLoad),
        .enable_i  (timerEnable),
        .expired_o (timerExpired)
    );

    assign bus.word_data     = wordData_q;
    assign bus.word_valid    = wordValid_q;
    assign bus.display_word  = errFlag_q ? {WORD_W{1'b1}} : wordData_q;
    assign bus.error_flag    = errFlag_q;
    assign bus.timeout_pulse = timeoutPulse_q;
    assign bus.byte_count    = byteCount_q;
    assign bus.busy          = (state_q == COLLECT);
    assign bus.err_count     = errCount_q;

endmodule
